// File: rtl/drop_lanes_pkg.sv
// Shared lane-state encodings and helpers for the drop_lanes falling-object generator.
package drop_lanes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_FALL   = 3'd2,
    ST_LANDED = 3'd3,
    ST_CAUGHT = 3'd4
  } lane_state_e;

  // Extra counter bits above the delay field so delay+LEAD never wraps.
  localparam int CNT_EXT_W = 7;

  function automatic logic is_settled(input lane_state_e s);
    return (s == ST_LANDED) || (s == ST_CAUGHT);
  endfunction

endpackage

// File: rtl/drop_lanes_if.sv
// Game-control / renderer bus of drop_lanes: control inputs and per-lane sprite outputs.
interface drop_lanes_if
  import drop_lanes_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int Y_W     = 7,
  parameter int DLY_W   = 9
) ();

  logic                       start;
  logic [N_LANES*DLY_W-1:0]   delay;
  logic [N_LANES-1:0]         catch;
  logic [N_LANES-1:0]         rearm;
  logic [N_LANES*Y_W-1:0]     y;
  logic [N_LANES-1:0]         visible;
  logic [N_LANES-1:0]         landed;
  logic [N_LANES-1:0]         caught;
  logic                       all_done;

  modport master (
    output start, delay, catch, rearm,
    input  y, visible, landed, caught, all_done
  );

  modport slave (
    input  start, delay, catch, rearm,
    output y, visible, landed, caught, all_done
  );

endinterface

// File: rtl/drop_lane.sv
// One lane: waits delay+LEAD clocks, then steps y from 0 to Y_MAX, ending LANDED or CAUGHT.
module drop_lane
  import drop_lanes_pkg::*;
#(
  parameter int Y_W      = 7,
  parameter int Y_MAX    = 63,
  parameter int DLY_W    = 9,
  parameter int LEAD     = 40,
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [DLY_W-1:0] i_delay,
  input  logic             i_catch,
  input  logic             i_rearm,
  output logic [Y_W-1:0]   o_y,
  output logic             o_visible,
  output logic             o_landed,
  output logic             o_caught,
  output logic             o_settle_next
);

  localparam int CNT_W = DLY_W + CNT_EXT_W;
  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(Y_MAX);
  localparam logic [CNT_W-1:0] LEAD_C   = CNT_W'(LEAD);

  lane_state_e      r_state;
  logic [CNT_W-1:0] r_count;
  logic [DIV_W-1:0] r_div;
  logic [DLY_W-1:0] r_dly_q;
  logic [Y_W-1:0]   r_y;
  logic [CNT_W-1:0] w_target;
  logic             w_step_last;
  logic             w_settle_next;

  assign w_target    = CNT_W'(r_dly_q) + LEAD_C;
  assign w_step_last = (r_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_div   <= '0;
      r_dly_q <= '0;
      r_y     <= '0;
    end else if (i_start) begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_WAIT;
          r_dly_q <= i_delay;
          r_count <= '0;
        end
        ST_WAIT: begin
          if (r_count == w_target) begin
            r_state <= ST_FALL;
            r_y     <= '0;
            r_div   <= '0;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        ST_FALL: begin
          // A catch freezes y even when a step is due in the same cycle.
          if (i_catch) begin
            r_state <= ST_CAUGHT;
          end else if (w_step_last) begin
            r_div <= '0;
            if (r_y == Y_LAST) begin
              r_state <= ST_LANDED;
            end else begin
              r_y <= r_y + Y_W'(1);
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        ST_LANDED, ST_CAUGHT: begin
          if (i_rearm) begin
            r_state <= ST_WAIT;
            r_dly_q <= i_delay;
            r_count <= '0;
            r_y     <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Lane will be LANDED or CAUGHT after this edge; feeds the registered all_done.
  always_comb begin
    w_settle_next = 1'b0;
    if (i_start) begin
      case (r_state)
        ST_FALL:              w_settle_next = i_catch | (w_step_last & (r_y == Y_LAST));
        ST_LANDED, ST_CAUGHT: w_settle_next = ~i_rearm;
        default:              w_settle_next = 1'b0;
      endcase
    end else begin
      w_settle_next = is_settled(r_state);
    end
  end

  assign o_y           = r_y;
  assign o_visible     = (r_state == ST_FALL);
  assign o_landed      = (r_state == ST_LANDED);
  assign o_caught      = (r_state == ST_CAUGHT);
  assign o_settle_next = w_settle_next;

endmodule

// File: rtl/drop_lanes.sv
// N_LANES independent drop_lane instances with bus packing and a registered all-lanes-settled flag.
module drop_lanes
  import drop_lanes_pkg::*;
#(
  parameter int N_LANES  = 4,
  parameter int Y_W      = 7,
  parameter int Y_MAX    = 63,
  parameter int DLY_W    = 9,
  parameter int LEAD     = 40,
  parameter int STEP_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  drop_lanes_if.slave bus
);

  logic [N_LANES*Y_W-1:0] w_y;
  logic [N_LANES-1:0]     w_visible;
  logic [N_LANES-1:0]     w_landed;
  logic [N_LANES-1:0]     w_caught;
  logic [N_LANES-1:0]     w_settle_next;
  logic                   r_all_done;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    drop_lane #(
      .Y_W      (Y_W),
      .Y_MAX    (Y_MAX),
      .DLY_W    (DLY_W),
      .LEAD     (LEAD),
      .STEP_DIV (STEP_DIV)
    ) u_lane (
      .clk           (clk),
      .i_reset       (reset),
      .i_start       (bus.start),
      .i_delay       (bus.delay[g*DLY_W +: DLY_W]),
      .i_catch       (bus.catch[g]),
      .i_rearm       (bus.rearm[g]),
      .o_y           (w_y[g*Y_W +: Y_W]),
      .o_visible     (w_visible[g]),
      .o_landed      (w_landed[g]),
      .o_caught      (w_caught[g]),
      .o_settle_next (w_settle_next[g])
    );
  end

  // Registered from next-state so it rises on the same edge the last lane settles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_all_done <= 1'b0;
    end else begin
      r_all_done <= &w_settle_next;
    end
  end

  assign bus.y        = w_y;
  assign bus.visible  = w_visible;
  assign bus.landed   = w_landed;
  assign bus.caught   = w_caught;
  assign bus.all_done = r_all_done;

endmodule
